// File: rtl/sevenseg_pkg.sv
// Shared constants and hex-to-segment decode for the seven-segment scan driver.
// Latency: combinational helpers only.
// Backpressure: none; pure constants and functions.
package sevenseg_pkg;

    localparam int SEG_W = 7;

    // Segment order is {a,b,c,d,e,f,g}, active high.
    localparam logic [SEG_W-1:0] SEG_BLANK = 7'b0000000;
    localparam logic [SEG_W-1:0] SEG_0     = 7'b1111110;
    localparam logic [SEG_W-1:0] SEG_1     = 7'b0110000;
    localparam logic [SEG_W-1:0] SEG_2     = 7'b1101101;
    localparam logic [SEG_W-1:0] SEG_3     = 7'b1111001;
    localparam logic [SEG_W-1:0] SEG_4     = 7'b0110011;
    localparam logic [SEG_W-1:0] SEG_5     = 7'b1011011;
    localparam logic [SEG_W-1:0] SEG_6     = 7'b1011111;
    localparam logic [SEG_W-1:0] SEG_7     = 7'b1110000;
    localparam logic [SEG_W-1:0] SEG_8     = 7'b1111111;
    localparam logic [SEG_W-1:0] SEG_9     = 7'b1111011;
    localparam logic [SEG_W-1:0] SEG_A     = 7'b1110111;
    localparam logic [SEG_W-1:0] SEG_B     = 7'b0011111;
    localparam logic [SEG_W-1:0] SEG_C     = 7'b1001110;
    localparam logic [SEG_W-1:0] SEG_D     = 7'b0111101;
    localparam logic [SEG_W-1:0] SEG_E     = 7'b1001111;
    localparam logic [SEG_W-1:0] SEG_F     = 7'b1000111;

    function automatic logic [SEG_W-1:0] seg_decode(input logic [3:0] nib);
        logic [SEG_W-1:0] pat;
        pat = SEG_BLANK;
        case (nib)
            4'h0: pat = SEG_0;
            4'h1: pat = SEG_1;
            4'h2: pat = SEG_2;
            4'h3: pat = SEG_3;
            4'h4: pat = SEG_4;
            4'h5: pat = SEG_5;
            4'h6: pat = SEG_6;
            4'h7: pat = SEG_7;
            4'h8: pat = SEG_8;
            4'h9: pat = SEG_9;
            4'hA: pat = SEG_A;
            4'hB: pat = SEG_B;
            4'hC: pat = SEG_C;
            4'hD: pat = SEG_D;
            4'hE: pat = SEG_E;
            default: pat = SEG_F;
        endcase
        return pat;
    endfunction

endpackage

// File: rtl/sevenseg_decode.sv
// Nibble to seven-segment pattern with a blanking override.
// Latency: combinational.
// Backpressure: none.
module sevenseg_decode
    import sevenseg_pkg::*;
(
    input  logic [3:0]       nibble_i,
    input  logic             blank_i,
    output logic [SEG_W-1:0] seg_o
);

    assign seg_o = blank_i ? SEG_BLANK : seg_decode(nibble_i);

endmodule

// File: rtl/sevenseg_scan.sv
// Time-multiplexed seven-segment scanner with frame-aligned double-buffered value.
// Latency: outputs update the cycle after each slot tick; load shows within DIGITS*REFRESH_DIV+1 cycles.
// Backpressure: none; later loads overwrite the shadow. SEVENSEG_LZB_EN enables leading-zero blanking.
module sevenseg_scan
    import sevenseg_pkg::*;
#(
    parameter int DIGITS      = 4,
    parameter int REFRESH_DIV = 50000
) (
    input  logic                  clk,
    input  logic                  rst_n,
    input  logic                  load,
    input  logic [4*DIGITS-1:0]   value,
    output logic                  pending,
    output logic [SEG_W-1:0]      segments,
    output logic [DIGITS-1:0]     grounds,
    output logic                  frame_tick
);

    localparam int DIV_W = (REFRESH_DIV > 1) ? $clog2(REFRESH_DIV) : 1;
    localparam int IDX_W = (DIGITS > 1) ? $clog2(DIGITS) : 1;
    localparam logic [DIV_W-1:0] DIV_LAST = DIV_W'(REFRESH_DIV - 1);
    localparam logic [IDX_W-1:0] IDX_LAST = IDX_W'(DIGITS - 1);

    logic [DIV_W-1:0]    div_q, div_d;
    logic [IDX_W-1:0]    idx_q, idx_d;
    logic [4*DIGITS-1:0] shadow_q, shadow_d;
    logic [4*DIGITS-1:0] active_q, active_d;
    logic                pending_q, pending_d;
    logic [SEG_W-1:0]    seg_q, seg_d;
    logic [DIGITS-1:0]   gnd_q, gnd_d;
    logic                ft_q, ft_d;

    logic                tick;
    logic                commit;
    logic [3:0]          nib;
    logic                blank;
    logic [SEG_W-1:0]    dec_seg;

    sevenseg_decode u_decode (
        .nibble_i (nib),
        .blank_i  (blank),
        .seg_o    (dec_seg)
    );

    // Divider, digit index and double-buffer update; commit only at the digit-0 slot.
    always_comb begin
        tick      = (div_q == DIV_LAST);
        commit    = tick && (idx_q == '0);
        div_d     = tick ? '0 : div_q + DIV_W'(1);
        idx_d     = idx_q;
        if (tick) begin
            idx_d = (idx_q == IDX_LAST) ? '0 : idx_q + IDX_W'(1);
        end
        shadow_d  = shadow_q;
        active_d  = active_q;
        pending_d = pending_q;
        if (commit) begin
            // A load landing on the commit cycle wins over the older shadow.
            if (load) begin
                active_d = value;
            end else if (pending_q) begin
                active_d = shadow_q;
            end
            pending_d = 1'b0;
        end else if (load) begin
            shadow_d  = value;
            pending_d = 1'b1;
        end
    end

    // Select the digit being scanned out of the post-commit value so digit 0 sees new data.
    always_comb begin
        nib   = 4'h0;
        blank = 1'b0;
        for (int i = 0; i < DIGITS; i++) begin
            if (idx_q == IDX_W'(i)) begin
                nib = active_d[4*i +: 4];
`ifdef SEVENSEG_LZB_EN
                blank = (i != 0) && ((active_d >> (4*i)) == '0);
`else
                blank = 1'b0;
`endif
            end
        end
    end

    // Output registers load on each slot tick and hold otherwise; frame_tick pulses on the digit-0 slot.
    always_comb begin
        seg_d = seg_q;
        gnd_d = gnd_q;
        if (tick) begin
            seg_d = dec_seg;
            gnd_d = DIGITS'(1) << idx_q;
        end
        ft_d = commit;
    end

    // All state resets asynchronously so the display goes dark immediately.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            div_q     <= '0;
            idx_q     <= '0;
            shadow_q  <= '0;
            active_q  <= '0;
            pending_q <= 1'b0;
            seg_q     <= '0;
            gnd_q     <= '0;
            ft_q      <= 1'b0;
        end else begin
            div_q     <= div_d;
            idx_q     <= idx_d;
            shadow_q  <= shadow_d;
            active_q  <= active_d;
            pending_q <= pending_d;
            seg_q     <= seg_d;
            gnd_q     <= gnd_d;
            ft_q      <= ft_d;
        end
    end

    assign pending    = pending_q;
    assign segments   = seg_q;
    assign grounds    = gnd_q;
    assign frame_tick = ft_q;

endmodule

// File: doc/sevenseg_scan.md
# sevenseg_scan

Time-multiplexed driver for a multi-digit common-cathode seven-segment display. It holds a `DIGITS`-nibble value and decodes each nibble as full hex (0–F). It scans one digit at a time at a programmable refresh rate, driving shared segment lines plus one digit-enable ("ground") line per digit. New values are double-buffered and committed only at frame start, so a displayed frame never mixes old and new digits. It sits between the datapath/CPU output register and the board display pins.

## Interface
- `DIGITS`, default 4: number of digits; legal range 1–8.
- `REFRESH_DIV`, default 50000: clock cycles per digit slot; legal ≥ 1.
- `clk`  in  1: single clock; all state on rising edge.
- `rst_n`  in  1: reset, asynchronous, active-low.
- `load`  in  1: single-cycle strobe; captures `value`.
- `value`  in  4*DIGITS: nibble i = digit i; digit 0 is least significant and rightmost.
- `pending`  out  1: high while a loaded value awaits commit.
- `segments`  out  7: active-high, bit 6..0 = a,b,c,d,e,f,g; registered.
- `grounds`  out  DIGITS: one-hot active-high digit enable; registered.
- `frame_tick`  out  1: one-cycle pulse on the slot that displays digit 0; registered.

## Operation
- State:
  - divider `div` counts 0..REFRESH_DIV-1.
  - `idx` holds the digit index, 0..DIGITS-1.
  - `shadow` and `active` are value registers.
  - `pending` flag.
- Slot tick: asserted in the cycle where `div == REFRESH_DIV-1`. On that cycle:
  - `div` returns to 0.
  - Outputs load the decode for digit `idx`.
  - `idx` increments, wrapping from DIGITS-1 to 0.
- Decode (hex): 0=1111110, 1=0110000, 2=1101101, 3=1111001, 4=0110011, 5=1011011, 6=1011111, 7=1110000, 8=1111111, 9=1111011, A=1110111, b=0011111, C=1001110, d=0111101, E=1001111, F=1000111.
- `load` with no commit in the same cycle: `shadow <= value`, `pending <= 1`. Repeated loads before commit overwrite; last wins.
- Commit happens on a slot tick with `idx == 0`:
  - If `pending`, `active <= shadow` and `pending <= 0`.
  - Digit 0 of that slot is decoded from the newly committed value (bypass).
- `load` in the same cycle as a commit: `value` bypasses directly into `active`, digit 0 decodes from `value`, and `pending <= 0`. The older `shadow` is discarded.
- `grounds` is one-hot of the digit being displayed. It is never multi-hot.
- DIGITS = 1: `idx` is always 0, every tick is a commit and raises `frame_tick`, and `grounds` = 1 after the first tick.

## Timing
- Reset values:
  - `segments` = 0, `grounds` = 0, `frame_tick` = 0, `pending` = 0.
  - `div` = 0, `idx` = 0, `shadow` = 0, `active` = 0.
- First tick occurs REFRESH_DIV cycles after reset release. Outputs are visible the following cycle: digit 0 showing the committed value, with `frame_tick` = 1.
- Digit k appears (k·REFRESH_DIV + REFRESH_DIV) cycles after reset, then every DIGITS·REFRESH_DIV cycles thereafter.
- Load-to-display latency is at most DIGITS·REFRESH_DIV + 1 cycles. `pending` rises the cycle after `load`.
- Outputs hold between ticks. `frame_tick` is high for exactly one cycle per frame.
- Reset asserted mid-frame clears all outputs immediately, without waiting for a clock edge. Any pending value is lost.

## Configuration
- `SEVENSEG_LZB_EN` defined: leading-zero blanking.
  - A digit i ≥ 1 is blanked (`segments` = 0, `grounds` still one-hot) when nibble i and all higher nibbles of the decoded value are 0.
  - Digit 0 is never blanked, so the value 0 still shows "0".
- `SEVENSEG_LZB_EN` undefined: all digits are always decoded, including leading zeros.

## Structure
- Package `sevenseg_pkg`:
  - 16 segment pattern constants.
  - Decode function: nibble in, 7-bit pattern out.
  - `SEG_BLANK` = 7'b0000000.
  - Segment width localparam.
- Sub-module `sevenseg_decode`: combinational nibble→pattern with a blank input. It wraps the package function.
- The top level holds the divider, index counter, shadow/active registers and output registers.

## Test plan
All scenarios use DIGITS=4, REFRESH_DIV=4.
- Reset: release `rst_n` → `segments`=0 and `grounds`=0 for 4 cycles. Then `grounds`=0001, `frame_tick`=1, `segments`=1111110.
- Scan: load 16'h12AF and wait one frame → observe:
  - `grounds`=0001 with 1000111 (F)
  - 0010 with 1110111 (A)
  - 0100 with 1101101 (2)
  - 1000 with 0110000 (1)
  - each digit held for 4 cycles.
- Deferred commit: load 16'h3333 while digit 2 is displayed → `pending`=1, and digits 2 and 3 still show old values. At the next digit-0 slot the display changes to 1111001 and `pending`=0.
- Collision: load 16'h0005 in the exact commit cycle while `shadow`=16'h9999 is pending → digit 0 shows 1011011 and `pending`=0.
- Leading-zero blanking (`SEVENSEG_LZB_EN`): value 16'h0070 → digit 3 blank, digit 2 blank, digit 1 shows 7, digit 0 shows 0. Value 0 → only digit 0 lit, showing 0.
- Reset mid-operation: assert `rst_n` low mid-slot with `pending`=1 → outputs go to 0 asynchronously. After release the display shows 0000 and `pending`=0.
